// File: rtl/dmem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake with a fixed wait-state count.
// Optional build macro DMEM_RESPONDER_ALIGN_CHK_EN rejects writes whose lane enables do not match the address alignment.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;

    logic [AW-1:0] index;
    logic          out_of_range;
    logic          align_err;
    logic          req_err;
    logic          accept;
    logic [3:0]    lane_we;
    logic [31:0]   rd_word;

    assign index        = req_addr[AW+1:2];
    assign out_of_range = |req_addr[31:AW+2];

`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
    // Legal writes: one byte at its own offset, a half on an even offset, or a full aligned word.
    always_comb begin
        align_err = 1'b0;
        case (req_we)
            4'b0000:                            align_err = 1'b0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: align_err = (req_we != (4'b0001 << req_addr[1:0]));
            4'b0011, 4'b1100:                   align_err = req_addr[0] || (req_we != (4'b0011 << req_addr[1:0]));
            4'b1111:                            align_err = (req_addr[1:0] != 2'b00);
            default:                            align_err = 1'b1;
        endcase
    end
`else
    logic unused_addr_lsb;
    assign align_err       = 1'b0;
    assign unused_addr_lsb = ^req_addr[1:0];
`endif

    assign req_err = out_of_range | align_err;
    assign accept  = req_valid && (state_reg == IDLE);
    assign lane_we = (accept && !req_err) ? req_we : 4'b0000;

    // One byte-wide array per lane so each lane's write enable maps onto its own RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem_lane[index] <= req_wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem_lane[index];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    count_next = WAIT_LOAD;
                    err_next   = req_err;
                    // rd_word is the pre-write contents; the lane writes land on the same edge.
                    rdata_next = req_err ? 32'd0 : rd_word;
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: constant vector table, hand-built corner sequences,
// then random traffic compared against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_we;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        bit          chk_rd;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: memory is a plain word array; error = beyond the array (or illegal lane set when aligned-checked).
    function automatic void ref_access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
        int idx;
        idx = int'(addr >> 2) % DEPTH;
        err = (addr >= 32'(DEPTH * 4));
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
        if (we != 4'b0000) begin
            int off;
            int n;
            int first;
            bit legal;
            off   = int'(addr[1:0]);
            n     = $countones(we);
            first = 0;
            while (we[first] == 1'b0) first++;
            legal = ((32'(we) >> first) == ((32'd1 << n) - 32'd1)) &&
                    (n == 1 || n == 2 || n == 4) && (first == off) && (off % n == 0);
            if (!legal) err = 1'b1;
        end
`endif
        rd = err ? 32'd0 : ref_mem[idx];
        if (!err) begin
            for (int l = 0; l < 4; l++) begin
                if (we[l]) ref_mem[idx][8*l +: 8] = wd[8*l +: 8];
            end
        end
    endfunction

    // One full transaction; hold = cycles of rsp_ready=0 backpressure, junk = drive ignored requests while busy.
    task automatic do_req(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                          input int hold, input bit junk, output logic [31:0] rd, output logic er);
        int lat;
        bit busy_ok;
        bit stable_ok;
        check("ready_idle", req_ready === 1'b1, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wd;
        step();
        if (junk) begin
            req_addr  = $urandom;
            req_we    = 4'hF;
            req_wdata = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        lat     = 1;
        busy_ok = 1'b1;
        while (rsp_valid !== 1'b1 && lat <= 20) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            step();
            lat++;
        end
        check("ready_busy", busy_ok, 32'(busy_ok), 32'd1);
        check("latency", lat == W + 1, 32'(lat), 32'(W + 1));
        rd = rsp_rdata;
        er = rsp_err;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        if (hold > 0) check("bp_stable", stable_ok, 32'(stable_ok), 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("ready_after_hs", req_ready === 1'b1 && rsp_valid === 1'b0,
              {30'd0, req_ready, rsp_valid}, 32'h2);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        logic        exp_er;
        bit          ok;

        vecs[0]  = '{32'h10,       4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{32'h10,       4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{32'h10,       4'b1111, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[3]  = '{32'h12,       4'b0100, 32'h00AB0000, 32'h11223344, 1'b0, 1'b1};
        vecs[4]  = '{32'h10,       4'b0000, 32'h0,        32'h11AB3344, 1'b0, 1'b1};
        vecs[5]  = '{32'h0,        4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{32'h400,      4'b1111, 32'h12345678, 32'h0,        1'b1, 1'b1};
        vecs[7]  = '{32'h0,        4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
        vecs[8]  = '{32'h80000010, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[9]  = '{32'h3FC,      4'b1111, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{32'h3FC,      4'b0000, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
`ifdef DMEM_RESPONDER_ALIGN_CHK_EN
        vecs[11] = '{32'h11,       4'b0011, 32'h0000BEEF, 32'h0,        1'b1, 1'b1};
        vecs[12] = '{32'h10,       4'b0000, 32'h0,        32'h11AB3344, 1'b0, 1'b1};
        vecs[13] = '{32'h13,       4'b1000, 32'h77000000, 32'h11AB3344, 1'b0, 1'b1};
`else
        vecs[11] = '{32'h11,       4'b0011, 32'h0000BEEF, 32'h11AB3344, 1'b0, 1'b1};
        vecs[12] = '{32'h10,       4'b0000, 32'h0,        32'h11ABBEEF, 1'b0, 1'b1};
        vecs[13] = '{32'h13,       4'b1000, 32'h77000000, 32'h11ABBEEF, 1'b0, 1'b1};
`endif

        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_we    = 4'd0;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        check("reset_outputs",
              req_ready === 1'b1 && rsp_valid === 1'b0 && rsp_rdata === 32'd0 && rsp_err === 1'b0,
              {rsp_rdata[29:0], rsp_valid, rsp_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            ref_access(vecs[i].addr, vecs[i].we, vecs[i].wdata, exp_rd, exp_er);
            do_req(vecs[i].addr, vecs[i].we, vecs[i].wdata, 0, 1'b0, rd, er);
            check($sformatf("vec%0d_err", i), er === vecs[i].exp_err, 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), rd === vecs[i].exp_rdata, rd, vecs[i].exp_rdata);
        end

        // Backpressure: response held for 5 cycles, must stay stable.
        ref_access(32'h10, 4'b0000, 32'h0, exp_rd, exp_er);
        do_req(32'h10, 4'b0000, 32'h0, 5, 1'b0, rd, er);
        check("bp_rdata", rd === exp_rd, rd, exp_rd);

        // Reset while in WAIT abandons the response; memory survives.
        req_valid = 1'b1;
        req_addr  = 32'h10;
        req_we    = 4'b0000;
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_async_valid", rsp_valid === 1'b0 && rsp_rdata === 32'd0,
              {rsp_rdata[30:0], rsp_valid}, 32'd0);
        step();
        reset = 1'b1;
        check("rst_release_ready", req_ready === 1'b1, 32'(req_ready), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
        end
        check("rst_no_stale_rsp", ok, 32'(ok), 32'd1);
        ref_access(32'h10, 4'b0000, 32'h0, exp_rd, exp_er);
        do_req(32'h10, 4'b0000, 32'h0, 0, 1'b0, rd, er);
        check("rst_mem_kept", rd === exp_rd, rd, exp_rd);

        // Fill every word so random reads always have a defined expectation.
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            ref_access(32'(i * 4), 4'b1111, d, exp_rd, exp_er);
            do_req(32'(i * 4), 4'b1111, d, 0, 1'b0, rd, er);
            check("fill_err", er === 1'b0, 32'(er), 32'd0);
        end

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            logic [3:0]  we;
            logic [31:0] d;
            a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            d  = $urandom;
            ref_access(a, we, d, exp_rd, exp_er);
            do_req(a, we, d, $urandom_range(0, 2), 1'b1, rd, er);
            check($sformatf("rnd%0d_err a=%h we=%b", t, a, we), er === exp_er, 32'(er), 32'(exp_er));
            check($sformatf("rnd%0d_rdata a=%h we=%b", t, a, we), rd === exp_rd, rd, exp_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
